// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared definitions for the pipelined carry-look-ahead adder:
//                stage-count computation, width-check macro and the
//                generate/propagate carry equations of a look-ahead group.
//  Revision    : 1.0 - initial release
// ============================================================================

// Elaboration-time guard: operand width must split evenly into groups, and a
// group must fit the look-ahead function's vector width.
`ifndef CLA_WIDTH_CHECK
`define CLA_WIDTH_CHECK(W, G) \
    if ((((W) % (G)) != 0) || ((G) < 1) || ((G) > cla_pkg::CLA_MAX_GROUP)) begin : g_width_check \
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP, GROUP <= CLA_MAX_GROUP"); \
    end
`endif

package cla_pkg;

    // Largest group the look-ahead carry function supports.
    localparam int CLA_MAX_GROUP = 32;

    // Number of pipeline stages for a given operand width and group size.
    function automatic int cla_nstage(input int width, input int group);
        return width / group;
    endfunction

    // Look-ahead carry out of bit idx in sum-of-products form:
    //   c[idx+1] = g[idx] | p[idx]g[idx-1] | ... | p[idx..0]c0
    // Bits above idx are ignored, so callers may zero-pad g/p.
    function automatic logic cla_carry(input logic [CLA_MAX_GROUP-1:0] g,
                                       input logic [CLA_MAX_GROUP-1:0] p,
                                       input logic                     c0,
                                       input int                       idx);
        logic c;
        logic pp;
        c  = 1'b0;
        pp = 1'b1;
        for (int j = CLA_MAX_GROUP - 1; j >= 0; j--) begin
            if (j <= idx) begin
                c  = c | (g[j] & pp);
                pp = pp & p[j];
            end
        end
        c = c | (c0 & pp);
        return c;
    endfunction

endpackage : cla_pkg

`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
//  Module      : cla_group
//  Description : Combinational GROUP-bit carry-look-ahead block. Produces the
//                sum slice, group generate/propagate, carry out and the carry
//                into the top bit (used for signed overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             g_out,
    output logic             p_out,
    output logic             c_out,
    output logic             c_msb
);

    logic [CLA_MAX_GROUP-1:0] w_g;
    logic [CLA_MAX_GROUP-1:0] w_p;
    logic [GROUP:0]           w_c;

    // Per-bit generate/propagate, zero-padded to the carry function's width.
    always_comb begin
        w_g              = '0;
        w_p              = '0;
        w_g[GROUP-1:0]   = a & b;
        w_p[GROUP-1:0]   = a ^ b;
    end

    assign w_c[0] = c_in;

    // Every internal carry is formed directly from g/p/c_in (no rippling).
    for (genvar i = 0; i < GROUP; i++) begin : g_carry
        assign w_c[i+1] = cla_carry(w_g, w_p, c_in, i);
    end

    assign s     = w_p[GROUP-1:0] ^ w_c[GROUP-1:0];
    assign g_out = cla_carry(w_g, w_p, 1'b0, GROUP - 1);
    assign p_out = &w_p[GROUP-1:0];
    assign c_out = w_c[GROUP];
    assign c_msb = w_c[GROUP-1];

endmodule : cla_group

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Pipelined carry-look-ahead adder/subtractor with valid/ready
//                handshake. One GROUP-bit slice is resolved per stage; the
//                slice carry is registered into the next stage. Results are
//                presented NSTAGE cycles after acceptance when unstalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSTAGE = cla_nstage(WIDTH, GROUP);
    localparam int c_last = NSTAGE - 1;

    `CLA_WIDTH_CHECK(WIDTH, GROUP)

    logic [NSTAGE-1:0] w_valid;
    logic [NSTAGE:0]   w_ready;

    // Ready chain in closed form: a stage can load unless it and every stage
    // downstream of it (including the output register) are full and the
    // consumer is stalling. Equivalent to ready_k = !valid_k || ready_{k+1}
    // but without a bit-to-bit dependency inside one vector.
    assign w_ready[NSTAGE] = out_ready || !out_valid;
    for (genvar k = 0; k < NSTAGE; k++) begin : g_ready
        assign w_ready[k] = out_ready || !(out_valid && (&w_valid[NSTAGE-1:k]));
    end

    assign in_ready = w_ready[0];

    // Stage k holds: the A word (low k*GROUP bits already replaced by sum
    // bits), the B bits not yet consumed, and the carry into slice k.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int c_lo = k * GROUP;
        localparam int c_bw = WIDTH - c_lo;

        logic             r_valid;
        logic [WIDTH-1:0] r_a;
        logic [c_bw-1:0]  r_b;
        logic             r_c;

        logic [GROUP-1:0] w_sum;
        logic             w_g;
        logic             w_p;
        logic             w_cout;
        logic             w_cmsb;
        logic [WIDTH-1:0] w_a_next;
        logic             w_unused_flags;

        assign w_valid[k] = r_valid;

        cla_group #(
            .GROUP (GROUP)
        ) u_group (
            .a     (r_a[c_lo +: GROUP]),
            .b     (r_b[GROUP-1:0]),
            .c_in  (r_c),
            .s     (w_sum),
            .g_out (w_g),
            .p_out (w_p),
            .c_out (w_cout),
            .c_msb (w_cmsb)
        );

        // Group generate/propagate are only needed by a two-level look-ahead;
        // with one group per stage the carry out is used directly.
        assign w_unused_flags = w_g ^ w_p ^ w_cmsb;

        // Splice this stage's resolved slice into the travelling word.
        always_comb begin
            w_a_next                    = r_a;
            w_a_next[c_lo +: GROUP]     = w_sum;
        end

        if (k == 0) begin : g_load_in
            // Capture operands; subtraction inverts B and forces carry-in.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_c     <= 1'b0;
                end else if (w_ready[0]) begin
                    r_valid <= in_valid;
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= sub ? ~b : b;
                        r_c <= sub | c_in;
                    end
                end
            end
        end else begin : g_load_prev
            // Advance the previous stage's partial result when this stage is free.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_c     <= 1'b0;
                end else if (w_ready[k]) begin
                    r_valid <= g_stage[k-1].r_valid;
                    if (g_stage[k-1].r_valid) begin
                        r_a <= g_stage[k-1].w_a_next;
                        r_b <= g_stage[k-1].r_b[c_bw+GROUP-1:GROUP];
                        r_c <= g_stage[k-1].w_cout;
                    end
                end
            end
        end
    end

    // Output register: final slice result, carry and signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else if (w_ready[NSTAGE]) begin
            out_valid <= w_valid[c_last];
            if (w_valid[c_last]) begin
                s     <= g_stage[c_last].w_a_next;
                c_out <= g_stage[c_last].w_cout;
                ovf   <= g_stage[c_last].w_cmsb ^ g_stage[c_last].w_cout;
            end
        end
    end

endmodule : cla_pipe_adder

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4):
//                directed vector table, reset mid-stream, backpressure stream
//                and a random handshake stream against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int GROUP  = 4;
    localparam int NSTAGE = 4;
    localparam int NVEC   = 14;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             c_in      = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    cla_pipe_adder #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: {ovf, carry, sum}; overflow from operand/result sign rule.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] full;
        logic        v;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, (sb ? 1'b1 : ci)};
        v    = (x[15] == yy[15]) && (full[15] != x[15]);
        return {v, full[16], full[15:0]};
    endfunction

    task automatic pick_op(input bit rnd, input int idx,
                           output logic [15:0] pa, output logic [15:0] pb,
                           output logic pci, output logic psub);
        if (rnd) begin
            pa   = 16'($urandom);
            pb   = 16'($urandom);
            pci  = 1'($urandom);
            psub = 1'($urandom);
        end else begin
            pa   = 16'(32'h0FFF * (idx + 1));
            pb   = 16'(32'h1001 * (idx + 1));
            pci  = 1'(idx >> 1);
            psub = 1'(idx);
        end
    endtask

    // Single op with out_ready high: check acceptance, latency, result, no repeat.
    task automatic apply_one(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        a = v.a; b = v.b; c_in = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1; sub = 1'b1;
        #1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check($sformatf("vec%0d latency", idx), 32'(lat), 32'(NSTAGE));
        check($sformatf("vec%0d result", idx), 32'({ovf, c_out, s}), 32'({v.v, v.c, v.s}));
        @(negedge clk);
        #1;
        check($sformatf("vec%0d no repeat", idx), 32'(out_valid), 32'd0);
    endtask

    // Streamed ops through the handshake; results compared in order.
    task automatic run_stream(input int n_ops, input bit rnd);
        logic [17:0] exp_q [$];
        logic [17:0] exp_v;
        logic [15:0] cur_a, cur_b, prev_s;
        logic        cur_ci, cur_sub;
        int          sent, got, cyc, limit;
        bit          prev_stall, saw_block;
        string       tag;
        sent = 0; got = 0; cyc = 0; prev_stall = 0; saw_block = 0; prev_s = '0;
        limit = n_ops * 8 + 100;
        tag   = rnd ? "random" : "stream";
        pick_op(rnd, sent, cur_a, cur_b, cur_ci, cur_sub);
        while (got < n_ops && cyc < limit) begin
            @(negedge clk);
            if (prev_stall)
                check({tag, " stall hold"}, 32'({out_valid, s}), 32'({1'b1, prev_s}));
            in_valid = (sent < n_ops) && (rnd ? ($urandom_range(0, 9) < 7) : 1'b1);
            if (in_valid) begin
                a = cur_a; b = cur_b; c_in = cur_ci; sub = cur_sub;
            end else begin
                a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
            end
            out_ready = rnd ? ($urandom_range(0, 9) < 7) : !(cyc >= 5 && cyc <= 9);
            #1;
            if (!in_ready) saw_block = 1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(cur_a, cur_b, cur_ci, cur_sub));
                sent++;
                pick_op(rnd, sent, cur_a, cur_b, cur_ci, cur_sub);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL %s spurious output: got 0x%0h, expected no result", tag, {ovf, c_out, s});
                end else begin
                    exp_v = exp_q.pop_front();
                    check({tag, " result"}, 32'({ovf, c_out, s}), 32'(exp_v));
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = s;
            cyc++;
        end
        check({tag, " results received"}, 32'(got), 32'(n_ops));
        if (!rnd)
            check("stream in_ready dropped", 32'(saw_block), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int cnt;
        // {a, b, c_in, sub, s, c_out, ovf}
        vecs[0]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};
        vecs[11] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[12] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[13] = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset state", 32'({in_ready, out_valid, ovf, c_out, s}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < NVEC; i++)
            apply_one(vecs[i], i);

        // Reset with three ops in flight, one already presented
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(32'h1000 * (i + 1)); b = 16'h0101; c_in = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset clears", 32'({out_valid, ovf, c_out, s}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) cnt++;
        end
        check("no stale after reset", 32'(cnt), 32'd0);

        // Backpressure: 8 back-to-back ops, out_ready low on cycles 5..9
        run_stream(8, 1'b0);

        // Random handshake stream
        run_stream(10000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_cla_pipe_adder

`default_nettype wire
